// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default operand width,
// controller states and the saturated quotient value.
package div_pkg;

    localparam int DW_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DW_DEFAULT-1:0] QUOT_ALL_ONES = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor when it fits.
module div_step #(
    parameter int DW = 64
) (
    input  logic [DW:0]   rem_in,
    input  logic          bit_in,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   rem_out,
    output logic          q_bit
);

    logic [DW+1:0] shifted;
    logic [DW+1:0] divisor_ext;

    // One extra bit keeps the shifted value exact even if rem_in uses its top bit.
    always_comb begin
        shifted     = {rem_in, bit_in};
        divisor_ext = {2'b00, divisor};
        q_bit       = (shifted >= divisor_ext);
        rem_out     = q_bit ? (DW+1)'(shifted - divisor_ext) : shifted[DW:0];
    end

endmodule

// File: rtl/div_128by64_seq.sv
// Sequential restoring divider: 2*DW-bit dividend by DW-bit divisor, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish in one cycle when the dividend is already below the divisor.
module div_128by64_seq
    import div_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero,
    output logic            overflow
);

    localparam int CW = $clog2(DW);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [DW:0]   prem, prem_next;
    logic [DW-1:0] qsh, dsr;
    logic [DW-1:0] div_hi, div_lo;
    logic          q_bit, accept, zero_div, ovf_det, early, skip, last;

    assign div_hi   = dividend[2*DW-1:DW];
    assign div_lo   = dividend[DW-1:0];
    assign accept   = (state == IDLE) && start;
    assign zero_div = (divisor == '0);
    assign ovf_det  = !zero_div && (div_hi >= divisor);
`ifdef DIV_EARLY_OUT_EN
    assign early    = !zero_div && (div_hi == '0) && (div_lo < divisor);
`else
    assign early    = 1'b0;
`endif
    assign skip     = zero_div || ovf_det || early;
    assign last     = (cnt == CW'(DW - 1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    div_step #(.DW(DW)) u_step (
        .rem_in  (prem),
        .bit_in  (qsh[DW-1]),
        .divisor (dsr),
        .rem_out (prem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = skip ? DONE : RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // qsh starts as the low dividend half; quotient bits fill it from the LSB as those bits leave.
    always_ff @(posedge clk) begin
        if (accept) begin
            prem <= {1'b0, div_hi};
            qsh  <= div_lo;
            dsr  <= divisor;
        end else if (state == RUN) begin
            prem <= prem_next;
            qsh  <= {qsh[DW-2:0], q_bit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            cnt         <= '0;
            div_by_zero <= zero_div;
            overflow    <= ovf_det;
            if (zero_div) begin
                quotient  <= DW'(QUOT_ALL_ONES);
                remainder <= div_lo;
            end else if (ovf_det) begin
                quotient  <= DW'(QUOT_ALL_ONES);
                remainder <= '0;
            end else if (early) begin
                quotient  <= '0;
                remainder <= div_lo;
            end
        end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
            if (last) begin
                quotient  <= {qsh[DW-2:0], q_bit};
                remainder <= prem_next[DW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_div_128by64_seq.sv
// Scoreboard bench for div_128by64_seq: the driver queues expected results from a
// plain-arithmetic model, the monitor compares them whenever done pulses.
module tb_div_128by64_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] dividend;
    logic [63:0]  divisor;
    logic         busy, done, div_by_zero, overflow;
    logic [63:0]  quotient, remainder;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dbz;
        logic        ovf;
        int          extra;     // edges from accept edge to done edge (also busy cycles)
        int          done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   timeouts = 0;
    int   busy_cnt = 0;
    bit   end_req  = 0;
    bit   end_ack  = 0;

    div_128by64_seq #(.DW(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic exp_t model(logic [127:0] dd, logic [63:0] dv);
        exp_t         e;
        logic [127:0] wide_dv;
        logic [127:0] q128, r128;
        e.dbz = 1'b0; e.ovf = 1'b0; e.extra = 64; e.done_cyc = 0;
        e.q = '0; e.r = '0;
        wide_dv = {64'd0, dv};
        if (dv == 64'd0) begin
            e.dbz = 1'b1; e.q = '1; e.r = dd[63:0]; e.extra = 0;
        end else if (dd[127:64] >= dv) begin
            e.ovf = 1'b1; e.q = '1; e.r = '0; e.extra = 0;
        end else begin
            q128 = dd / wide_dv;
            r128 = dd % wide_dv;
            e.q = q128[63:0];
            e.r = r128[63:0];
`ifdef DIV_EARLY_OUT_EN
            if (dd[127:64] == 64'd0 && dd[63:0] < dv) e.extra = 0;
`endif
        end
        return e;
    endfunction

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
            check("rst_busy", 128'(busy), 0);
            check("rst_done", 128'(done), 0);
            check("rst_quotient", 128'(quotient), 0);
            check("rst_remainder", 128'(remainder), 0);
            check("rst_div_by_zero", 128'(div_by_zero), 0);
            check("rst_overflow", 128'(overflow), 0);
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("quotient", 128'(quotient), 128'(e.q));
                    check("remainder", 128'(remainder), 128'(e.r));
                    check("div_by_zero", 128'(div_by_zero), 128'(e.dbz));
                    check("overflow", 128'(overflow), 128'(e.ovf));
                    check("done_cycle", 128'(cyc), 128'(e.done_cyc));
                    check("busy_cycles", 128'(busy_cnt), 128'(e.extra));
                end
                busy_cnt = 0;
            end
        end
        if (end_req && !end_ack) begin
            check("scoreboard_drained", 128'(exp_q.size()), 0);
            check("timeouts", 128'(timeouts), 0);
            end_ack = 1;
        end
    end

    task automatic run_op(input logic [127:0] dd, input logic [63:0] dv,
                          input bit poke_run, input bit poke_done);
        exp_t e;
        int   n;
        e = model(dd, dv);
        @(negedge clk);
        start = 1'b1; dividend = dd; divisor = dv;
        @(posedge clk);
        #1;
        e.done_cyc = cyc + e.extra;
        exp_q.push_back(e);
        start = 1'b0;
        dividend = {$urandom, $urandom, $urandom, $urandom};
        divisor  = {$urandom, $urandom};
        if (poke_run && e.extra > 10) begin
            repeat (8) @(posedge clk);
            @(negedge clk);
            start = 1'b1; divisor = 64'd0;
            @(posedge clk);
            #1 start = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        if (!done) timeouts++;
        if (poke_done) begin
            start = 1'b1; divisor = 64'd0;
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    task automatic abort_op(input logic [127:0] dd, input logic [63:0] dv);
        @(negedge clk);
        start = 1'b1; dividend = dd; divisor = dv;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (29) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] dv, hi, lo;
        int          mode;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        run_op(128'd33486686868, 64'd2, 1'b1, 1'b1);
        run_op(128'd100, 64'd7, 1'b0, 1'b0);
        run_op({64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        run_op(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 64'd0, 1'b0, 1'b0);
        run_op({64'd5, 64'd0}, 64'd5, 1'b0, 1'b1);
        run_op(128'd3, 64'd10, 1'b1, 1'b0);
        abort_op(128'd33486686868, 64'd2);
        run_op(128'd100, 64'd7, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            mode = int'($urandom_range(0, 5));
            dv = {$urandom, $urandom};
            hi = {$urandom, $urandom};
            lo = {$urandom, $urandom};
            case (mode)
                0: dv = 64'd0;
                1: dv = 64'($urandom_range(1, 1000));
                2: begin
                    hi = 64'd0;
                    lo = 64'($urandom_range(0, 50));
                    dv = 64'($urandom_range(1, 100));
                end
                default: begin
                    if (dv == 64'd0) dv = 64'd1;
                    hi = hi % dv;
                end
            endcase
            run_op({hi, lo}, dv, (i % 7) == 0, (i % 5) == 0);
        end

        repeat (3) @(posedge clk);
        end_req = 1;
        for (int i = 0; i < 10 && !end_ack; i++) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
